// File: rtl/param_data_shuffler.sv
// param_data_shuffler: two-lane FFT commutator with per-2D-block bypass (in: clk, rst, in_valid, bypass, a, b; out: a1, b1, out_valid, sel_mon)
module param_data_shuffler #(
  parameter int W = 32,
  parameter int D = 4,
  parameter int LOG2D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         bypass,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] a1,
  output logic [W-1:0] b1,
  output logic         out_valid,
  output logic         sel_mon
);
  localparam logic [LOG2D:0] full = (LOG2D+1)'(D);
  localparam logic [LOG2D:0] one = (LOG2D+1)'(1);
  logic [LOG2D:0] cnt, fill;
  logic mode, byp, s;
  logic [W-1:0] db [D];
  logic [W-1:0] da [D];
  logic [W-1:0] m0, m1;
  assign sel_mon = cnt[LOG2D];
  always_comb begin
    byp = cnt == '0 ? bypass : mode;
    s = sel_mon & ~byp;
    m0 = s ? db[D-1] : a;
    m1 = s ? a : db[D-1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      fill <= '0;
      mode <= 1'b0;
      a1 <= '0;
      b1 <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < D; i++) begin
        db[i] <= '0;
        da[i] <= '0;
      end
    end else begin
      out_valid <= in_valid && fill == full;
      if (in_valid) begin
        cnt <= cnt + one;
        fill <= fill == full ? fill : fill + one;
        mode <= byp;
        a1 <= da[D-1];
        b1 <= m1;
        db[0] <= b;
        da[0] <= m0;
        for (int i = 1; i < D; i++) begin
          db[i] <= db[i-1];
          da[i] <= da[i-1];
        end
      end
    end
endmodule

// File: tb/tb_param_data_shuffler.sv
// tb_param_data_shuffler: randomized and directed check of param_data_shuffler against a block-level model
module tb_param_data_shuffler;
  localparam int D = 4;
  logic clk = 0, rst = 1;
  logic v = 0, byp = 0;
  logic [31:0] a = 0, b = 0;
  logic [31:0] a1, b1;
  logic ov, sm;
  logic s_v = 0;
  logic [31:0] s_a = 0, s_b = 0, s_a1, s_b1;
  logic s_ov, s_sm;
  int errors = 0, checks = 0;
  int la1[16] = '{0, 1, 2, 3, 100, 101, 102, 103, 8, 9, 10, 11, 108, 109, 110, 111};
  int lb1[16] = '{4, 5, 6, 7, 104, 105, 106, 107, 12, 13, 14, 15, 112, 113, 114, 115};
  int l1a[4] = '{1, 2, 5, 6};
  int l1b[4] = '{3, 4, 7, 8};
  always #5 clk = ~clk;
  param_data_shuffler #(.W(32), .D(D), .LOG2D(2)) dut (
    .clk(clk), .rst(rst), .in_valid(v), .bypass(byp), .a(a), .b(b),
    .a1(a1), .b1(b1), .out_valid(ov), .sel_mon(sm)
  );
  param_data_shuffler #(.W(32), .D(1), .LOG2D(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_v), .bypass(1'b0), .a(s_a), .b(s_b),
    .a1(s_a1), .b1(s_b1), .out_valid(s_ov), .sel_mon(s_sm)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  logic [31:0] ah[$], bh[$];
  bit mh[$];
  int nv = 0;
  logic [31:0] pa1 = 0, pb1 = 0;
  always begin : cmp
    logic cr, cv, cb;
    logic [31:0] ca, cbv, ea, eb;
    int q, m, r;
    @(posedge clk);
    cr = rst; cv = v; cb = byp; ca = a; cbv = b;
    #1;
    if (cr) begin
      ah.delete(); bh.delete(); mh.delete(); nv = 0;
    end else if (cv) begin
      if (nv % (2*D) == 0) mh.push_back(cb);
      ah.push_back(ca); bh.push_back(cbv); nv++;
    end
    chk("sel_mon", 32'(sm), ((nv % (2*D)) >= D) ? 32'd1 : 32'd0);
    if (!cr && cv && nv > D) begin
      q = nv - 1 - D; m = q / (2*D); r = q % (2*D);
      if (mh[m]) begin ea = ah[q]; eb = bh[q]; end
      else if (r < D) begin ea = ah[q]; eb = ah[q+D]; end
      else begin ea = bh[q-D]; eb = bh[q]; end
      chk("out_valid", 32'(ov), 1);
      chk("a1", a1, ea);
      chk("b1", b1, eb);
    end else begin
      chk("out_valid_low", 32'(ov), 0);
      if (cr) begin
        chk("a1_rst", a1, 0);
        chk("b1_rst", b1, 0);
      end else if (!cv) begin
        chk("a1_hold", a1, pa1);
        chk("b1_hold", b1, pb1);
      end
    end
    pa1 = a1; pb1 = b1;
  end
  task automatic drive(input logic vv, input logic bb, input logic [31:0] aa, input logic [31:0] bv);
    v = vv; byp = bb; a = aa; b = bv;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1; v = 0;
    @(negedge clk);
    rst = 0;
  endtask
  task automatic run_t2(input int gap);
    for (int k = 0; k < 20; k++) begin
      drive(1, 0, 32'(k), 32'(100 + k));
      if (k >= 4) begin
        chk("t2_ov", 32'(ov), 1);
        chk("t2_a1", a1, 32'(la1[k-4]));
        chk("t2_b1", b1, 32'(lb1[k-4]));
      end else chk("t2_ov_fill", 32'(ov), 0);
      if (gap != 0 && k % 2 == 1) repeat (3) drive(0, 1, $urandom, $urandom);
    end
  endtask
  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      s_v = 1; s_a = 32'(2*i + 1); s_b = 32'(2*i + 2);
      @(negedge clk);
      chk("d1_sel", 32'(s_sm), 32'((i + 1) % 2));
      if (i == 0) chk("d1_ov_fill", 32'(s_ov), 0);
      else begin
        chk("d1_ov", 32'(s_ov), 1);
        chk("d1_a1", s_a1, 32'(l1a[i-1]));
        chk("d1_b1", s_b1, 32'(l1b[i-1]));
      end
    end
    s_v = 0;
    do_reset;
    run_t2(0);
    do_reset;
    run_t2(1);
    do_reset;
    for (int k = 0; k < 24; k++) begin
      drive(1, (k < 8) || (k >= 11 && k < 16), 32'(k), 32'(100 + k));
      if (k >= 4 && k < 12) begin
        chk("byp_a1", a1, 32'(k - 4));
        chk("byp_b1", b1, 32'(100 + k - 4));
      end else if (k >= 12 && k < 16) begin
        chk("late_byp_a1", a1, 32'(k - 4));
        chk("late_byp_b1", b1, 32'(k));
      end
    end
    do_reset;
    for (int k = 0; k < 13; k++) drive(1, 0, 32'(k), 32'(100 + k));
    rst = 1;
    #1;
    chk("async_a1", a1, 0);
    chk("async_b1", b1, 0);
    chk("async_ov", 32'(ov), 0);
    chk("async_sel", 32'(sm), 0);
    @(negedge clk);
    rst = 0;
    run_t2(0);
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset;
      else drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_data_shuffler.md
Name: param_data_shuffler

Overview:
Parametrised two-lane data shuffler (commutator) for the 2-parallel FFT datapath. It sits between butterfly stages and exchanges the second D-sample half of lane a with the first D-sample half of lane b in every 2D-sample block, which transposes the lane pairing for the next stage. Unlike the fixed 32-bit unit with an external select, it has:
- configurable width and delay depth
- an internal switch counter
- input valid gating with output valid
- a block-aligned bypass mode

Parameters:
W, 32, data width of each lane in bits.
D, 4, commutator delay depth in samples; must be a power of 2, D >= 1.
LOG2D, 2, log2(D). Must match D; the counter is LOG2D+1 bits wide.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies a and b; all internal state advances only on cycles where it is 1.
bypass  input  1  mode request; sampled only at block start.
a  input  W  lane-a input sample.
b  input  W  lane-b input sample.
a1  output  W  lane-a output sample, registered.
b1  output  W  lane-b output sample, registered.
out_valid  output  1  a1 and b1 hold a new valid pair.
sel_mon  output  1  current switch state (counter MSB), for debug and verification.

Behaviour:
- Reset, asynchronous on rst=1:
  - counter, fill count, both D-deep delay lines and a1/b1 all cleared to 0.
  - out_valid=0, mode register=shuffle, sel_mon=0.
  - A reset asserted mid-block discards all in-flight data. After release, the first valid input is block sample 0.
- Counter: LOG2D+1 bits. Increments by 1 on each in_valid cycle and wraps from 2D-1 to 0. sel = counter MSB, so sel=0 for block samples 0..D-1 and sel=1 for D..2D-1.
- Mode: on an in_valid cycle with counter==0, mode is loaded from bypass. Mode holds for the whole 2D block. A bypass change mid-block has no effect until the next block.
- Effective switch: s = sel AND (mode==shuffle).
- Datapath, evaluated on each in_valid cycle:
  - d1 = lane b delayed by D valid samples (D-deep shift register).
  - If s=0: m0=a, m1=d1.
  - If s=1: m0=d1, m1=a.
  - a1 <= m0 delayed by D valid samples (second D-deep shift register).
  - b1 <= m1.
- Holding: on in_valid=0 cycles nothing shifts and a1, b1 and the counter hold.
- Fill and out_valid:
  - Fill counter saturates at D and increments on each in_valid cycle.
  - out_valid <= in_valid AND (fill==D), registered. It is deasserted on any cycle without in_valid.
- Latency: D valid samples plus 1 clock (output register), identical for both lanes in both modes.
- Shuffle mode output sequence, in steady state per 2D block:
  - a1 = a[0..D-1], b[0..D-1]
  - b1 = a[D..2D-1], b[D..2D-1]
- Bypass mode: a1 = a delayed, b1 = b delayed, with the same latency. Mode switching at a block boundary therefore produces no gap or duplicate.
- Simultaneous events: rst overrides in_valid. in_valid with counter wrap and mode load in the same cycle is legal; the new mode applies to that sample.
- Width: all datapath signals are exactly W bits, with no arithmetic on data.

Test Plan:
1. D=1, W=32, in_valid=1 continuously, a=1,3,5,7 and b=2,4,6,8 on consecutive cycles -> (a1,b1) = (1,3), (2,4), (5,7), (6,8) on consecutive cycles, with out_valid=1 from the first pair.
2. D=4, a=k and b=100+k for k=0..15 continuous -> a1 = 0,1,2,3,100,101,102,103,8,...,11,108,...,111 and b1 = 4,...,7,104,...,107,12,...,15,112,...,115. out_valid rises 1 clock after the 5th valid input.
3. Test 2 with in_valid=0 inserted for 3 cycles after every 2nd sample -> identical a1/b1 value sequence on out_valid cycles. Outputs hold and out_valid=0 during gaps.
4. D=4, bypass=1 at block start -> a1 = a[k-4], b1 = b[k-4]. bypass toggled at block sample 3 -> mode changes only at the next counter==0.
5. Assert rst at block sample 5 of 8 in D=4 streaming, then restart with a=k, b=100+k -> outputs, out_valid and sel_mon go to 0 immediately. After restart, the sequence is exactly as in test 2 with no stale data.
